// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the instruction register side and the operand-mux side
// of the immediate generator. The producer and the consumer are both on the master side.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_type;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_instr, in_type, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_type, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate decoder/extender with a main register plus one skid
// register, so in_ready is purely registered and the consumer can stall freely.
module imm_gen_pipe #(
  parameter int XLEN     = 64,
  parameter int BR_SHIFT = 1,
  parameter int TAG_W    = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           flush,
  imm_gen_pipe_if.slave  bus,
  output logic [7:0]     illegal_count
);

  localparam int EW = XLEN + TAG_W + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t            state_reg, state_next;
  logic [EW-1:0]   main_reg, main_next;
  logic [EW-1:0]   skid_reg, skid_next;
  logic [EW-1:0]   new_entry;
  logic [7:0]      count_reg, count_next;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            accept;
  logic            drain;

  // Raw immediate fields held as signed so a size cast sign-extends them.
  logic signed [11:0] i_field;
  logic signed [11:0] s_field;
  logic signed [11:0] sb_field;
  logic signed [19:0] uj_field;
  logic signed [31:0] u_field;
  logic [5:0]         shamt_field;
  logic               unused_opcode;

  assign i_field     = bus.in_instr[31:20];
  assign s_field     = {bus.in_instr[31:25], bus.in_instr[11:7]};
  assign sb_field    = {bus.in_instr[31], bus.in_instr[7], bus.in_instr[30:25], bus.in_instr[11:8]};
  assign uj_field    = {bus.in_instr[31], bus.in_instr[19:12], bus.in_instr[20], bus.in_instr[30:21]};
  assign u_field     = {bus.in_instr[31:12], 12'b0};
  assign shamt_field = (XLEN == 64) ? bus.in_instr[25:20] : {1'b0, bus.in_instr[24:20]};
  assign unused_opcode = ^bus.in_instr[6:0];

  always_comb begin
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (bus.in_type)
      3'b000:  dec_imm = XLEN'(i_field);
      3'b001:  dec_imm = XLEN'(s_field);
      3'b010:  dec_imm = XLEN'(sb_field) << BR_SHIFT;
      3'b011:  dec_imm = XLEN'(uj_field) << BR_SHIFT;
      3'b100:  dec_imm = XLEN'(u_field);
      3'b101:  dec_imm = XLEN'(bus.in_instr[19:15]);
      3'b110:  dec_imm = XLEN'(shamt_field);
      default: dec_illegal = 1'b1;
    endcase
  end

  assign new_entry = {dec_imm, bus.in_tag, dec_illegal};

  // Both handshake outputs decode straight from the occupancy register.
  assign bus.in_ready  = (state_reg != TWO);
  assign bus.out_valid = (state_reg != EMPTY);
  assign {bus.out_imm, bus.out_tag, bus.out_illegal} = main_reg;
  assign illegal_count = count_reg;

  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = bus.out_valid & bus.out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    count_next = count_reg;

    case (state_reg)
      EMPTY: begin
        if (accept) begin
          main_next  = new_entry;
          state_next = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_next = new_entry;
        end else if (accept) begin
          skid_next  = new_entry;
          state_next = TWO;
        end else if (drain) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          main_next  = skid_reg;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase

    if (accept && dec_illegal && !flush && count_reg != 8'hFF) begin
      count_next = count_reg + 8'd1;
    end

    // Flush wins over everything, including an entry accepted at this edge.
    if (flush) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: doc/imm_gen_pipe.md
Name:
imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate sign-extender.
- Decodes and sign- or zero-extends RISC-V immediates to XLEN bits, including two extra immediate kinds: CSR zimm and shift amount.
- Has valid/ready handshakes on both sides, with a 2-entry skid buffer so the decode stage can stall without losing instructions.
- Sits between the instruction register and the ALU/branch-target operand muxes. It also flags and counts illegal immediate types.

Parameters:
- XLEN, 64, output width; legal values 32 or 64.
- BR_SHIFT, 1, left shift applied to SB and UJ immediates; legal values 1 (RISC-V standard) or 2 (legacy word-offset mode).
- TAG_W, 8, width of the sideband tag (e.g. PC index) carried alongside each entry.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  input entry valid.
- in_ready  out  1  block can accept an entry.
- in_instr  in  32  instruction word.
- in_type  in  3  immediate kind selector.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the output entry.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the output entry.
- out_illegal  out  1  output entry had an illegal in_type.
- illegal_count  out  8  saturating count of accepted illegal entries.

Behaviour:
- Reset: asynchronous, active-high; the clock is single-domain.
  - While reset is high, every register clears: out_valid=0, out_imm=0, out_tag=0, out_illegal=0, illegal_count=0, skid buffer empty, in_ready=1.
  - in_valid is ignored while reset is high. Reset asserted mid-transfer drops all entries.
- Decode is combinational on in_instr; the result is registered. imm12 and imm20 fields use standard RV bit positions.
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25], instr[11:7]}).
  - 010 SB: sext({instr[31], instr[7], instr[30:25], instr[11:8]}) << BR_SHIFT.
  - 011 UJ: sext({instr[31], instr[19:12], instr[20], instr[30:21]}) << BR_SHIFT.
  - 100 U: sext({instr[31:12], 12'b0}).
  - 101 Z: zext(instr[19:15]).
  - 110 SHAMT: zext(instr[25:20]) when XLEN=64; zext(instr[24:20]) when XLEN=32.
  - 111: illegal; imm=0, illegal=1.
- Sign extension replicates the top bit of the shifted field up to bit XLEN-1. When XLEN=32, the U result is exactly {instr[31:12], 12'b0}.
- Storage: an output register (main) plus one skid register. An entry is {imm, tag, illegal}.
- Occupancy states and transitions:
  - EMPTY: accept moves to ONE.
  - ONE: accept with no drain moves to TWO. Accept with drain stays in ONE. Drain with no accept moves to EMPTY.
  - TWO: in_ready=0. Drain moves the skid entry into main and goes to ONE.
- Handshake rules:
  - Accept = in_valid & in_ready. Drain = out_valid & out_ready.
  - in_ready = !skid_valid. It is a registered signal, so there is no combinational path from out_ready.
  - out_valid = main_valid.
- Latency: an entry accepted at edge N is presented at out_* after edge N, when the buffer is EMPTY or when main drains at the same edge.
- Order is strictly FIFO. out_imm, out_tag and out_illegal hold stable while out_valid=1 and out_ready=0.
- Simultaneous accept and drain in ONE: main loads the new entry; the skid stays empty.
- flush=1 at an edge: both entries are invalidated. Any entry accepted at that same edge is discarded and is not counted.
- illegal_count increments by 1 at each accepted in_type=111 entry when flush=0, and saturates at 255. Only reset clears it.

Test Plan:
- XLEN=64, BR_SHIFT=1, out_ready=1. Send in_instr=0xFFF00093, type 000, tag 0x11 → next cycle out_valid=1, out_imm=0xFFFF_FFFF_FFFF_FFFF, out_tag=0x11.
- Send 0x123450B7 then 0x800000B7, both type 100 → out_imm=0x0000_0000_1234_5000, then 0xFFFF_FFFF_8000_0000, on consecutive cycles.
- Send 0xFE000EE3 type 010 → 0xFFFF_FFFF_FFFF_FFFC. Repeat with BR_SHIFT=2 → 0xFFFF_FFFF_FFFF_FFF8. Send type 101 with instr[19:15]=0x1F → 0x1F.
- Hold out_ready=0 and offer tags A, B, C back-to-back → in_ready falls after B is accepted; C is held off. Raise out_ready → outputs A, B, C in order with no loss or duplication.
- Send 300 entries of type 111 → each has out_illegal=1 and out_imm=0; illegal_count reads 255 at the end.
- With 2 entries buffered, assert flush together with a new accept → next cycle out_valid=0, in_ready=1, count unchanged. Assert reset asynchronously mid-stream → all outputs 0 immediately.
